tx_source_arbiter: RTL and testbench

- Round-robin scheduler that decides which source's completed message goes next to the Slave FIFO write path.
- Sits between the per-source message buffers (full-message flags, length bus) and the FX2 slave FIFO read/write controller. The controller sequences writes only for the source this block grants.
- Adds per-source enable masking, message-length sanity checking with drop, a watchdog on grant duration, and a guard gap between messages.

---
 rtl/tx_source_arbiter.sv | 174 +++++++++++++++++
 tb/tb_tx_source_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_source_arbiter.sv
// Round-robin grant scheduler for buffered TX messages feeding the slave FIFO writer.
// Adds enable masking, length sanity drop, a grant watchdog and an inter-message guard gap.
module tx_source_arbiter #(
   parameter int NUM_SOURCES = 4,
   parameter int MAX_LEN     = 255,
   parameter int WDOG_LIMIT  = 1024,
   parameter int GAP_CYCLES  = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [NUM_SOURCES-1:0]     REQ,
   input  logic [NUM_SOURCES-1:0]     SRC_ENABLE,
   input  logic [NUM_SOURCES*8-1:0]   MSG_LEN_BUS,
   input  logic                       DONE,
   input  logic                       ERR_CLR,
   output logic                       GRANT_VALID,
   output logic [3:0]                 GRANT_ID,
   output logic [NUM_SOURCES-1:0]     GRANT_ONEHOT,
   output logic [7:0]                 GRANT_LEN,
   output logic [NUM_SOURCES-1:0]     DROP,
   output logic                       LEN_ERR,
   output logic                       WDOG_ERR,
   output logic [1:0]                 STATE_MON
);

   localparam int WDOG_W = (WDOG_LIMIT > 2) ? $clog2(WDOG_LIMIT) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t                 state, state_n;
   logic [3:0]             ptr, ptr_n;
   logic [WDOG_W-1:0]      wdog_cnt, wdog_n;
   logic [GAP_W-1:0]       gap_cnt, gap_n;
   logic                   valid_q, valid_n;
   logic [3:0]             id_q, id_n;
   logic [7:0]             len_q, len_n;
   logic [NUM_SOURCES-1:0] drop_q, drop_n;
   logic                   len_err_q, len_err_n;
   logic                   wdog_err_q, wdog_err_n;

   logic [15:0]            elig_pad;
   logic [127:0]           len_pad;
   logic                   found;
   logic [3:0]             pick;
   logic [4:0]             idx;
   logic [7:0]             pick_len;

   function automatic logic len_bad(input logic [7:0] len);
      return (len == 8'd0) || (int'(len) > MAX_LEN);
   endfunction

   function automatic logic [NUM_SOURCES-1:0] onehot(input logic [3:0] id);
      logic [NUM_SOURCES-1:0] oh;
      for (int i = 0; i < NUM_SOURCES; i++)
         oh[i] = (id == 4'(i));
      return oh;
   endfunction

   // Pad to 16 sources so a 4-bit index always selects in range.
   assign elig_pad = 16'(REQ & SRC_ENABLE);
   assign len_pad  = 128'(MSG_LEN_BUS);
   assign pick_len = len_pad[{pick, 3'b000} +: 8];

   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         idx = {1'b0, ptr} + 5'(i);
         if (idx > 5'(NUM_SOURCES - 1))
            idx = idx - 5'(NUM_SOURCES);
         if (!found && elig_pad[idx[3:0]]) begin
            found = 1'b1;
            pick  = idx[3:0];
         end
      end
   end

   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      wdog_n     = wdog_cnt;
      gap_n      = gap_cnt;
      valid_n    = valid_q;
      id_n       = id_q;
      len_n      = len_q;
      drop_n     = '0;
      len_err_n  = len_err_q & ~ERR_CLR;
      wdog_err_n = wdog_err_q & ~ERR_CLR;
      case (state)
         ST_IDLE: begin
            if (found) begin
               id_n  = pick;
               len_n = pick_len;
               ptr_n = (pick == 4'(NUM_SOURCES - 1)) ? 4'd0 : pick + 4'd1;
               if (len_bad(pick_len)) begin
                  drop_n    = onehot(pick);
                  len_err_n = 1'b1;
                  state_n   = ST_GAP;
               end else begin
                  valid_n = 1'b1;
                  wdog_n  = '0;
                  state_n = ST_GRANT;
               end
            end
         end
         ST_GRANT: begin
            // A DONE arriving on the timeout cycle still counts as a clean finish.
            if (DONE) begin
               valid_n = 1'b0;
               wdog_n  = '0;
               state_n = ST_GAP;
            end else if (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1)) begin
               wdog_err_n = 1'b1;
               valid_n    = 1'b0;
               wdog_n     = '0;
               state_n    = ST_GAP;
            end else begin
               wdog_n = wdog_cnt + 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
               gap_n   = '0;
               state_n = ST_IDLE;
            end else begin
               gap_n = gap_cnt + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         wdog_cnt   <= '0;
         gap_cnt    <= '0;
         valid_q    <= 1'b0;
         id_q       <= '0;
         len_q      <= '0;
         drop_q     <= '0;
         len_err_q  <= 1'b0;
         wdog_err_q <= 1'b0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         wdog_cnt   <= wdog_n;
         gap_cnt    <= gap_n;
         valid_q    <= valid_n;
         id_q       <= id_n;
         len_q      <= len_n;
         drop_q     <= drop_n;
         len_err_q  <= len_err_n;
         wdog_err_q <= wdog_err_n;
      end
   end

   assign GRANT_VALID  = valid_q;
   assign GRANT_ID     = id_q;
   assign GRANT_ONEHOT = valid_q ? onehot(id_q) : '0;
   assign GRANT_LEN    = len_q;
   assign DROP         = drop_q;
   assign LEN_ERR      = len_err_q;
   assign WDOG_ERR     = wdog_err_q;
   assign STATE_MON    = state;

endmodule

// File: tb/tb_tx_source_arbiter.sv
// Scoreboard bench for tx_source_arbiter: a transaction-level model queues expected
// grant/end/drop events; a negedge monitor pops them as the DUT presents them.
module tb_tx_source_arbiter;
   localparam int N    = 4;
   localparam int MAXL = 200;
   localparam int WDOG = 16;
   localparam int GAP  = 2;

   localparam int EV_GRANT = 0;
   localparam int EV_END   = 1;
   localparam int EV_DROP  = 2;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic [N-1:0]   REQ = '0;
   logic [N-1:0]   SRC_ENABLE = '0;
   logic [7:0]     lens [N];
   logic [N*8-1:0] MSG_LEN_BUS;
   logic           DONE = 1'b0;
   logic           ERR_CLR = 1'b0;
   logic           GRANT_VALID;
   logic [3:0]     GRANT_ID;
   logic [N-1:0]   GRANT_ONEHOT;
   logic [7:0]     GRANT_LEN;
   logic [N-1:0]   DROP;
   logic           LEN_ERR;
   logic           WDOG_ERR;
   logic [1:0]     STATE_MON;

   assign MSG_LEN_BUS = {lens[3], lens[2], lens[1], lens[0]};

   tx_source_arbiter #(
      .NUM_SOURCES(N), .MAX_LEN(MAXL), .WDOG_LIMIT(WDOG), .GAP_CYCLES(GAP)
   ) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .SRC_ENABLE(SRC_ENABLE),
      .MSG_LEN_BUS(MSG_LEN_BUS), .DONE(DONE), .ERR_CLR(ERR_CLR),
      .GRANT_VALID(GRANT_VALID), .GRANT_ID(GRANT_ID), .GRANT_ONEHOT(GRANT_ONEHOT),
      .GRANT_LEN(GRANT_LEN), .DROP(DROP), .LEN_ERR(LEN_ERR), .WDOG_ERR(WDOG_ERR),
      .STATE_MON(STATE_MON)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int kind;
      int cyc;
      int id;
      int len;
   } ev_t;

   ev_t sb_q[$];
   int  seen_ids[$];
   int  cyc = 0;
   int  tests = 0;
   int  fails = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: the arbiter is either busy with one grant or free from a given cycle on.
   bit  m_busy = 1'b0;
   int  m_start, m_id, m_len;
   int  m_idle_at = 0;
   int  m_ptr = 0;
   bit  e_len_err = 1'b0;
   bit  e_wdog_err = 1'b0;
   bit  set_len, set_wdog;
   int  elig, k, ln;
   ev_t ev_m;

   always @(posedge CLK) begin
      cyc++;
      if (RST) begin
         m_busy = 1'b0; m_ptr = 0; m_idle_at = 0;
         e_len_err = 1'b0; e_wdog_err = 1'b0;
         sb_q.delete();
      end else begin
         set_len  = 1'b0;
         set_wdog = 1'b0;
         elig     = int'(REQ & SRC_ENABLE);
         if (m_busy) begin
            if (DONE || (cyc - m_start) == WDOG) begin
               set_wdog  = !DONE;
               m_busy    = 1'b0;
               m_idle_at = cyc + GAP + 1;
               ev_m = '{kind: EV_END, cyc: cyc, id: m_id, len: m_len};
               sb_q.push_back(ev_m);
            end
         end else if (cyc >= m_idle_at && elig != 0) begin
            k = -1;
            for (int i = 0; i < N; i++)
               if (k < 0 && ((elig >> ((m_ptr + i) % N)) & 1) == 1)
                  k = (m_ptr + i) % N;
            m_ptr = (k + 1) % N;
            ln    = int'(lens[k]);
            if (ln == 0 || ln > MAXL) begin
               set_len   = 1'b1;
               m_idle_at = cyc + GAP + 1;
               ev_m = '{kind: EV_DROP, cyc: cyc, id: k, len: ln};
            end else begin
               m_busy  = 1'b1;
               m_start = cyc;
               m_id    = k;
               m_len   = ln;
               ev_m = '{kind: EV_GRANT, cyc: cyc, id: k, len: ln};
            end
            sb_q.push_back(ev_m);
         end
         e_len_err  = set_len  || (e_len_err  && !ERR_CLR);
         e_wdog_err = set_wdog || (e_wdog_err && !ERR_CLR);
      end
   end

   // Monitor
   bit  prev_v = 1'b0;
   bit  rise, fall, drp;
   int  kind_seen;
   ev_t ev_d;

   always @(negedge CLK) begin
      if (RST) begin
         prev_v = 1'b0;
      end else begin
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            chk("event_missing", -1, sb_q[0].kind);
            void'(sb_q.pop_front());
         end
         rise = GRANT_VALID && !prev_v;
         fall = !GRANT_VALID && prev_v;
         drp  = (DROP != '0);
         if (rise || fall || drp) begin
            kind_seen = drp ? EV_DROP : (rise ? EV_GRANT : EV_END);
            if (sb_q.size() == 0) begin
               chk("event_unexpected", kind_seen, -1);
            end else begin
               ev_d = sb_q.pop_front();
               chk("event_kind", kind_seen, ev_d.kind);
               chk("event_cycle", cyc, ev_d.cyc);
               chk("grant_id", int'(GRANT_ID), ev_d.id);
               chk("grant_len", int'(GRANT_LEN), ev_d.len);
               case (ev_d.kind)
                  EV_GRANT: begin
                     chk("grant_onehot", int'(GRANT_ONEHOT), 1 << ev_d.id);
                     chk("state_grant", int'(STATE_MON), 1);
                     seen_ids.push_back(int'(GRANT_ID));
                  end
                  EV_END: begin
                     chk("end_onehot", int'(GRANT_ONEHOT), 0);
                     chk("state_gap_end", int'(STATE_MON), 2);
                  end
                  default: begin
                     chk("drop_vec", int'(DROP), 1 << ev_d.id);
                     chk("drop_no_valid", int'(GRANT_VALID), 0);
                     chk("state_gap_drop", int'(STATE_MON), 2);
                  end
               endcase
            end
         end
         chk("len_err_flag", int'(LEN_ERR), int'(e_len_err));
         chk("wdog_err_flag", int'(WDOG_ERR), int'(e_wdog_err));
         prev_v = GRANT_VALID;
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic pulse_done();
      DONE = 1'b1;
      step();
      DONE = 1'b0;
   endtask

   task automatic wait_rise(input string nm);
      int n = 0;
      while (!GRANT_VALID && n < 100) begin
         step();
         n++;
      end
      chk(nm, int'(GRANT_VALID), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int r;
      for (int i = 0; i < N; i++) lens[i] = 8'd10;
      RST = 1'b1;
      step();
      chk("rst_valid", int'(GRANT_VALID), 0);
      chk("rst_id", int'(GRANT_ID), 0);
      chk("rst_onehot", int'(GRANT_ONEHOT), 0);
      chk("rst_len", int'(GRANT_LEN), 0);
      chk("rst_drop", int'(DROP), 0);
      chk("rst_len_err", int'(LEN_ERR), 0);
      chk("rst_wdog_err", int'(WDOG_ERR), 0);
      chk("rst_state", int'(STATE_MON), 0);
      RST = 1'b0;

      // All sources requesting: strict rotation
      REQ = '1; SRC_ENABLE = '1;
      seen_ids.delete();
      for (int g = 0; g < 5; g++) begin
         wait_rise("p1_rise");
         repeat (3) step();
         pulse_done();
      end
      REQ = '0;
      repeat (4) step();
      chk("p1_count", seen_ids.size(), 5);
      for (int g = 0; g < seen_ids.size() && g < 5; g++)
         chk("p1_order", seen_ids[g], g % N);

      // Disabled source is never granted until enabled
      REQ = 4'b0100; SRC_ENABLE = 4'b1011;
      repeat (10) step();
      chk("p2_masked", int'(GRANT_VALID), 0);
      SRC_ENABLE = '1;
      step();
      chk("p2_valid", int'(GRANT_VALID), 1);
      chk("p2_id", int'(GRANT_ID), 2);
      chk("p2_onehot", int'(GRANT_ONEHOT), 4);
      step();
      pulse_done();
      REQ = '0;
      repeat (4) step();

      // Zero and oversize lengths are dropped
      lens[1] = 8'd0;
      REQ = 4'b0010;
      step();
      REQ = '0;
      step();
      chk("p3_len_err", int'(LEN_ERR), 1);
      chk("p3_no_grant", int'(GRANT_VALID), 0);
      ERR_CLR = 1'b1;
      step();
      ERR_CLR = 1'b0;
      chk("p3_len_err_clr", int'(LEN_ERR), 0);
      repeat (3) step();
      lens[2] = 8'd201;
      REQ = 4'b0100;
      step();
      REQ = '0;
      repeat (3) step();
      chk("p3_oversize_err", int'(LEN_ERR), 1);
      ERR_CLR = 1'b1;
      step();
      ERR_CLR = 1'b0;
      for (int i = 0; i < N; i++) lens[i] = 8'd10;
      repeat (3) step();

      // Watchdog timeout on source 3, then rotation continues at 0
      REQ = 4'b1000;
      wait_rise("p4_rise");
      REQ = '1;
      n = 0;
      while (GRANT_VALID && n < 40) begin
         step();
         n++;
      end
      chk("p4_wdog_span", n, WDOG);
      chk("p4_wdog_err", int'(WDOG_ERR), 1);
      wait_rise("p4_next_rise");
      chk("p4_next_id", int'(GRANT_ID), 0);
      pulse_done();
      REQ = '0;
      ERR_CLR = 1'b1;
      step();
      ERR_CLR = 1'b0;
      chk("p4_wdog_clr", int'(WDOG_ERR), 0);
      repeat (4) step();

      // Request withdrawn mid-grant: grant and latched length hold
      REQ = 4'b0001;
      wait_rise("p5_rise");
      repeat (2) step();
      REQ = '0;
      lens[0] = 8'd77;
      repeat (4) step();
      chk("p5_held", int'(GRANT_VALID), 1);
      chk("p5_len_latched", int'(GRANT_LEN), 10);
      pulse_done();
      lens[0] = 8'd10;
      repeat (4) step();

      // Asynchronous reset mid-grant
      REQ = 4'b0100;
      wait_rise("p6_rise");
      chk("p6_id", int'(GRANT_ID), 2);
      repeat (2) step();
      #5;
      RST = 1'b1;
      #1;
      chk("p6_async_valid", int'(GRANT_VALID), 0);
      chk("p6_async_id", int'(GRANT_ID), 0);
      chk("p6_async_onehot", int'(GRANT_ONEHOT), 0);
      chk("p6_async_len", int'(GRANT_LEN), 0);
      chk("p6_async_state", int'(STATE_MON), 0);
      REQ = '1;
      step();
      step();
      RST = 1'b0;
      wait_rise("p6_after_rise");
      chk("p6_after_id", int'(GRANT_ID), 0);
      pulse_done();
      REQ = '0;
      repeat (4) step();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) REQ = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0)
            SRC_ENABLE = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               r = int'($urandom_range(0, 9));
               if (r == 0)      lens[i] = 8'd0;
               else if (r == 1) lens[i] = 8'($urandom_range(MAXL + 1, 255));
               else             lens[i] = 8'($urandom_range(1, MAXL));
            end
         end
         DONE    = ($urandom_range(0, 5) == 0);
         ERR_CLR = ($urandom_range(0, 30) == 0);
         step();
      end
      REQ = '0;
      ERR_CLR = 1'b0;
      DONE = 1'b1;
      repeat (20) step();
      DONE = 1'b0;
      repeat (5) step();
      chk("sb_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
